graph_query_sched: RTL and testbench
====================================

// Module: graph_query_sched
// PURPOSE
// - Round-robin scheduler for the shared graph path-search engine (FORWARD/BACKWARD level search over the 65-node edge-mask graph).
// - Accepts (start, end) path queries from N_REQ requesters and launches one query at a time on the engine.
// - Applies a watchdog to every query and returns {status, level count} to the requester that issued it.
// PARAMETERS
// - N_REQ     4      number of requesters (2..8)
// - NODE_W    7      node index width
// - NODES     65     valid node indices are 0..NODES-1
// - LEV_W     4      level count width
// - MAX_LEV   10     level limit driven to the engine
// - TMO_W     12     watchdog counter width; timeout after 2**TMO_W-1 WAIT cycles
// PORTS
// - CLK         in   1             clock, all logic on posedge
// - RST_n       in   1             reset, synchronous, active-low
// - req_valid   in   N_REQ         per-requester query valid
// - req_ready   out  N_REQ         one-hot accept strobe
// - req_start   in   N_REQ*NODE_W  start node; slice i belongs to requester i
// - req_end     in   N_REQ*NODE_W  end node; slice i belongs to requester i
// - rsp_valid   out  N_REQ         one-hot response valid
// - rsp_ready   in   N_REQ         per-requester response accept
// - rsp_status  out  2             0=FOUND 1=NOPATH 2=BADARG 3=TIMEOUT
// - rsp_len     out  LEV_W         path level count; 0 unless FOUND
// - eng_start   out  1             one-cycle launch pulse
// - eng_abort   out  1             one-cycle abort pulse
// - eng_src     out  NODE_W        start node to engine; held from LAUNCH to end of query
// - eng_dst     out  NODE_W        end node to engine; held from LAUNCH to end of query
// - eng_maxlev  out  LEV_W         level limit to engine; constant MAX_LEV
// - eng_done    in   1             one-cycle completion pulse
// - eng_found   in   1             completion result; valid with eng_done
// - eng_len     in   LEV_W         completion level count; valid with eng_done
// BEHAVIOUR
// - Reset (RST_n=0 at posedge):
//   - state=IDLE, rr_ptr=0, all outputs 0.
//   - eng_maxlev=MAX_LEV.
//   - Reset mid-query drops the query with no response; the engine is reinitialised by its own reset.
// - FSM states: IDLE, GRANT, LAUNCH, WAIT, RESP, ABORT.
// - IDLE: if any req_valid, go to GRANT.
//   - Winner = first set bit of req_valid searching from rr_ptr upward, with wrap-around.
// - GRANT (1 cycle):
//   - Assert req_ready[winner] for exactly this cycle.
//   - Latch src, dst and owner=winner.
//   - Set rr_ptr=(winner+1) mod N_REQ.
//   - If src>=NODES or dst>=NODES: status=BADARG, go to RESP without starting the engine.
//   - Else if src==dst: status=FOUND, len=0, go to RESP.
//   - Else go to LAUNCH.
// - LAUNCH (1 cycle): eng_start=1, clear watchdog, go to WAIT.
// - WAIT: watchdog increments each cycle.
//   - On eng_done: status=FOUND with len=eng_len if eng_found=1; else NOPATH with len=0. Go to RESP.
//   - If the watchdog reaches all-ones before eng_done: status=TIMEOUT, go to ABORT.
//   - eng_done in the same cycle as the watchdog reaching all-ones: done wins.
// - ABORT (1 cycle): eng_abort=1, go to RESP.
// - RESP:
//   - Assert rsp_valid[owner] with status and len stable until rsp_ready[owner]=1.
//   - On handshake go to IDLE; the next grant is possible 1 cycle later.
// - Ignored inputs:
//   - eng_done outside WAIT is ignored.
//   - rsp_ready of non-owners is ignored.
// - Request rules:
//   - A requester withdrawing req_valid before its grant is legal.
//   - Payload is sampled only in GRANT.
// - Latency:
//   - Non-engine (BADARG, trivial FOUND): grant to rsp_valid = 1 cycle.
//   - Engine: rsp_valid 1 cycle after eng_done.
// - At most one query outstanding. Width rules: all comparisons unsigned; eng_len passes through unmodified.
// TESTING
// - Reset, then req_valid=4'b0001, src=3, dst=40; engine returns done/found/len=5 after 20 cycles -> rsp_valid=0001, FOUND, len=5.
// - req_valid=4'b1111 held, engine answers instantly -> grant order 0,1,2,3,0, and each grant is one-hot.
// - src=70 -> BADARG; src=dst=12 -> FOUND, len=0. In both cases eng_start never pulses.
// - Engine never answers -> eng_abort pulses 4096 cycles after eng_start, then rsp TIMEOUT.
// - rsp_ready held 0 for 50 cycles -> rsp fields stable, no new grant. Then eng_done asserted during RESP -> ignored.
// - RST_n=0 during WAIT -> all outputs 0 the next cycle. After release, rr_ptr=0 and the next grant goes to the lowest valid requester.

Source files
------------

// File: rtl/graph_query_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | graph_query_sched_if                                                       |
// | Request, response and engine-control bundle for the graph query scheduler. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface graph_query_sched_if #(
    parameter int N_REQ  = 4,
    parameter int NODE_W = 7,
    parameter int LEV_W  = 4
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*NODE_W-1:0] req_start;
    logic [N_REQ*NODE_W-1:0] req_end;
    logic [N_REQ-1:0]        rsp_valid;
    logic [N_REQ-1:0]        rsp_ready;
    logic [1:0]              rsp_status;
    logic [LEV_W-1:0]        rsp_len;
    logic                    eng_start;
    logic                    eng_abort;
    logic [NODE_W-1:0]       eng_src;
    logic [NODE_W-1:0]       eng_dst;
    logic [LEV_W-1:0]        eng_maxlev;
    logic                    eng_done;
    logic                    eng_found;
    logic [LEV_W-1:0]        eng_len;

    // Requesters and engine side
    modport master (
        output req_valid, req_start, req_end, rsp_ready, eng_done, eng_found, eng_len,
        input  req_ready, rsp_valid, rsp_status, rsp_len,
        input  eng_start, eng_abort, eng_src, eng_dst, eng_maxlev
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_start, req_end, rsp_ready, eng_done, eng_found, eng_len,
        output req_ready, rsp_valid, rsp_status, rsp_len,
        output eng_start, eng_abort, eng_src, eng_dst, eng_maxlev
    );
endinterface
`default_nettype wire

// File: rtl/graph_query_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | graph_query_sched                                                          |
// | Round-robin launcher for the shared graph path-search engine with watchdog.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module graph_query_sched #(
    parameter int N_REQ   = 4,
    parameter int NODE_W  = 7,
    parameter int NODES   = 65,
    parameter int LEV_W   = 4,
    parameter int MAX_LEV = 10,
    parameter int TMO_W   = 12
) (
    input  wire logic              CLK,
    input  wire logic              RST_n,
    graph_query_sched_if.slave     bus
);
    localparam int                 c_IDX_W   = $clog2(N_REQ);
    localparam logic [c_IDX_W:0]   c_NREQ_W  = (c_IDX_W+1)'(N_REQ);
    localparam logic [c_IDX_W-1:0] c_LAST    = c_IDX_W'(N_REQ-1);
    localparam logic [NODE_W:0]    c_NODES   = (NODE_W+1)'(NODES);
    localparam logic [TMO_W-1:0]   c_WD_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [1:0]         c_FOUND   = 2'd0;
    localparam logic [1:0]         c_NOPATH  = 2'd1;
    localparam logic [1:0]         c_BADARG  = 2'd2;
    localparam logic [1:0]         c_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4,
        S_ABORT  = 3'd5
    } state_t;

    state_t             r_state;
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [c_IDX_W-1:0] r_owner;
    logic [TMO_W-1:0]   r_wd;
    logic [N_REQ-1:0]   r_req_ready;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [1:0]         r_rsp_status;
    logic [LEV_W-1:0]   r_rsp_len;
    logic               r_eng_start;
    logic               r_eng_abort;
    logic [NODE_W-1:0]  r_src;
    logic [NODE_W-1:0]  r_dst;

    logic [c_IDX_W:0]   w_sum;
    logic [c_IDX_W-1:0] w_winner;
    logic               w_hit;
    logic [NODE_W-1:0]  w_src;
    logic [NODE_W-1:0]  w_dst;
    logic               w_bad;
    logic [N_REQ-1:0]   w_owner_oh;
    logic [c_IDX_W-1:0] w_ptr_next;

    // First valid requester at or after the round-robin pointer, wrapping
    always_comb begin
        w_winner = '0;
        w_hit    = 1'b0;
        w_sum    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (c_IDX_W+1)'(k);
            if (w_sum >= c_NREQ_W) begin
                w_sum = w_sum - c_NREQ_W;
            end
            if (!w_hit && bus.req_valid[w_sum[c_IDX_W-1:0]]) begin
                w_hit    = 1'b1;
                w_winner = w_sum[c_IDX_W-1:0];
            end
        end
    end

    assign w_src      = bus.req_start[r_owner*NODE_W +: NODE_W];
    assign w_dst      = bus.req_end[r_owner*NODE_W +: NODE_W];
    assign w_bad      = ({1'b0, w_src} >= c_NODES) || ({1'b0, w_dst} >= c_NODES);
    assign w_owner_oh = N_REQ'(1) << r_owner;
    assign w_ptr_next = (r_owner == c_LAST) ? '0 : r_owner + 1'b1;

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_wd         <= '0;
            r_req_ready  <= '0;
            r_rsp_valid  <= '0;
            r_rsp_status <= '0;
            r_rsp_len    <= '0;
            r_eng_start  <= 1'b0;
            r_eng_abort  <= 1'b0;
            r_src        <= '0;
            r_dst        <= '0;
        end else begin
            r_req_ready <= '0;
            r_eng_start <= 1'b0;
            r_eng_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_owner     <= w_winner;
                        r_req_ready <= N_REQ'(1) << w_winner;
                        r_state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_src    <= w_src;
                    r_dst    <= w_dst;
                    r_rr_ptr <= w_ptr_next;
                    if (w_bad) begin
                        r_rsp_status <= c_BADARG;
                        r_rsp_len    <= '0;
                        r_rsp_valid  <= w_owner_oh;
                        r_state      <= S_RESP;
                    end else if (w_src == w_dst) begin
                        r_rsp_status <= c_FOUND;
                        r_rsp_len    <= '0;
                        r_rsp_valid  <= w_owner_oh;
                        r_state      <= S_RESP;
                    end else begin
                        r_eng_start <= 1'b1;
                        r_state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_wd    <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_wd <= r_wd + 1'b1;
                    // A completion on the final watchdog cycle still counts
                    if (bus.eng_done) begin
                        r_rsp_status <= bus.eng_found ? c_FOUND : c_NOPATH;
                        r_rsp_len    <= bus.eng_found ? bus.eng_len : '0;
                        r_rsp_valid  <= w_owner_oh;
                        r_state      <= S_RESP;
                    end else if (r_wd == c_WD_LAST) begin
                        r_eng_abort <= 1'b1;
                        r_state     <= S_ABORT;
                    end
                end
                S_ABORT: begin
                    r_rsp_status <= c_TIMEOUT;
                    r_rsp_len    <= '0;
                    r_rsp_valid  <= w_owner_oh;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (|(bus.rsp_ready & r_rsp_valid)) begin
                        r_rsp_valid  <= '0;
                        r_rsp_status <= '0;
                        r_rsp_len    <= '0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_status = r_rsp_status;
    assign bus.rsp_len    = r_rsp_len;
    assign bus.eng_start  = r_eng_start;
    assign bus.eng_abort  = r_eng_abort;
    assign bus.eng_src    = r_src;
    assign bus.eng_dst    = r_dst;
    assign bus.eng_maxlev = LEV_W'(MAX_LEV);
endmodule
`default_nettype wire

// File: tb/tb_graph_query_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_graph_query_sched                                                       |
// | Randomized self-checking bench against a transaction-level reference model.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_graph_query_sched;
    localparam int c_N     = 4;
    localparam int c_NODES = 65;

    logic CLK;
    logic RST_n;
    int   n_tests;
    int   n_fail;
    int   m_rr;
    logic [6:0] p_st [c_N];
    logic [6:0] p_en [c_N];

    graph_query_sched_if #(.N_REQ(4), .NODE_W(7), .LEV_W(4)) bus ();

    graph_query_sched #(
        .N_REQ(4), .NODE_W(7), .NODES(65), .LEV_W(4), .MAX_LEV(10), .TMO_W(12)
    ) u_dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int exp_winner(input logic [3:0] m, input int rr);
        for (int k = 0; k < c_N; k++) begin
            if (m[(rr + k) % c_N]) return (rr + k) % c_N;
        end
        return 0;
    endfunction

    // mode 0: engine answers after d WAIT cycles; 1: engine silent; 2: reset during WAIT
    task automatic do_txn(input logic [3:0] mask, input int mode, input int d,
                          input logic fnd, input logic [3:0] ln, input int hold);
        int         w;
        int         cnt;
        logic [3:0] oh;
        logic [1:0] e_st;
        logic [3:0] e_len;
        logic       engine;
        for (int i = 0; i < c_N; i++) begin
            bus.req_start[i*7 +: 7] = p_st[i];
            bus.req_end[i*7 +: 7]   = p_en[i];
        end
        bus.req_valid = mask;
        w  = exp_winner(mask, m_rr);
        oh = 4'b0001 << w;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (bus.req_ready == 4'b0 && cnt < 8);
        chk("grant", bus.req_ready, oh);
        bus.req_valid = '0;
        m_rr = (w + 1) % c_N;

        engine = 1'b0;
        if (p_st[w] >= c_NODES || p_en[w] >= c_NODES) begin
            e_st = 2'd2; e_len = 4'd0;
        end else if (p_st[w] == p_en[w]) begin
            e_st = 2'd0; e_len = 4'd0;
        end else begin
            engine = 1'b1;
            e_st  = (mode == 1) ? 2'd3 : (fnd ? 2'd0 : 2'd1);
            e_len = (mode == 0 && fnd) ? ln : 4'd0;
        end

        tick();
        if (!engine) begin
            chk("direct_start", bus.eng_start, 1'b0);
            chk("direct_rsp", {bus.rsp_valid, bus.rsp_status, bus.rsp_len}, {oh, e_st, e_len});
        end else begin
            chk("launch", {bus.eng_start, bus.eng_src, bus.eng_dst, bus.eng_maxlev, bus.rsp_valid},
                {1'b1, p_st[w], p_en[w], 4'd10, 4'b0});
            if (mode == 1) begin
                cnt = 0;
                do begin
                    tick();
                    cnt++;
                end while (!bus.eng_abort && cnt < 5000);
                chk("abort_cycles", cnt, 4096);
                tick();
            end else if (mode == 2) begin
                repeat (3) tick();
                RST_n = 1'b0;
                tick();
                chk("reset_outs", {bus.req_ready, bus.rsp_valid, bus.rsp_status, bus.rsp_len,
                                   bus.eng_start, bus.eng_abort, bus.eng_src, bus.eng_dst}, '0);
                chk("reset_maxlev", bus.eng_maxlev, 4'd10);
                RST_n = 1'b1;
                m_rr  = 0;
                return;
            end else begin
                repeat (d + 1) tick();
                bus.eng_done  = 1'b1;
                bus.eng_found = fnd;
                bus.eng_len   = ln;
                tick();
                bus.eng_done  = 1'b0;
                chk("hold_src", {bus.eng_src, bus.eng_dst}, {p_st[w], p_en[w]});
            end
            chk("eng_rsp", {bus.rsp_valid, bus.rsp_status, bus.rsp_len}, {oh, e_st, e_len});
        end

        for (int h = 0; h < hold; h++) begin
            bus.rsp_ready = 4'($urandom) & ~oh;
            bus.req_valid = 4'($urandom_range(1, 15));
            bus.eng_done  = ($urandom_range(0, 3) == 0);
            bus.eng_found = 1'b1;
            bus.eng_len   = 4'($urandom);
            tick();
            chk("rsp_stable", {bus.rsp_valid, bus.rsp_status, bus.rsp_len, bus.req_ready,
                               bus.eng_start, bus.eng_abort}, {oh, e_st, e_len, 4'b0, 2'b0});
        end
        bus.eng_done  = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = oh | 4'($urandom);
        tick();
        bus.rsp_ready = '0;
        chk("rsp_drop", bus.rsp_valid, 4'b0);
    endtask

    function automatic logic [6:0] rnd_node();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 7'($urandom_range(c_NODES, 127));
        return 7'($urandom_range(0, c_NODES - 1));
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_rr    = 0;
        RST_n   = 1'b0;
        bus.req_valid = '0; bus.req_start = '0; bus.req_end = '0;
        bus.rsp_ready = '0; bus.eng_done = 1'b0; bus.eng_found = 1'b0; bus.eng_len = '0;
        for (int i = 0; i < c_N; i++) begin p_st[i] = 7'd1; p_en[i] = 7'd2; end
        repeat (3) tick();
        chk("reset_outs", {bus.req_ready, bus.rsp_valid, bus.rsp_status, bus.rsp_len,
                           bus.eng_start, bus.eng_abort, bus.eng_src, bus.eng_dst}, '0);
        chk("reset_maxlev", bus.eng_maxlev, 4'd10);
        RST_n = 1'b1;

        p_st[0] = 7'd3; p_en[0] = 7'd40;
        do_txn(4'b0001, 0, 19, 1'b1, 4'd5, 0);

        for (int i = 0; i < c_N; i++) begin p_st[i] = 7'(i + 1); p_en[i] = 7'(i + 20); end
        repeat (5) do_txn(4'b1111, 0, 0, 1'b1, 4'd3, 0);

        p_st[1] = 7'd70; p_en[1] = 7'd5;
        do_txn(4'b0010, 0, 0, 1'b0, 4'd0, 2);
        p_st[2] = 7'd12; p_en[2] = 7'd12;
        do_txn(4'b0100, 0, 0, 1'b0, 4'd0, 1);
        p_st[3] = 7'd1; p_en[3] = 7'd65;
        do_txn(4'b1000, 0, 0, 1'b0, 4'd0, 0);
        p_st[0] = 7'd64; p_en[0] = 7'd0;
        do_txn(4'b0001, 0, 4, 1'b0, 4'd9, 0);

        p_st[1] = 7'd8; p_en[1] = 7'd9;
        do_txn(4'b0010, 1, 0, 1'b0, 4'd0, 3);

        p_st[2] = 7'd30; p_en[2] = 7'd31;
        do_txn(4'b0100, 0, 2, 1'b1, 4'd15, 50);

        p_st[3] = 7'd10; p_en[3] = 7'd11;
        do_txn(4'b1000, 2, 0, 1'b0, 4'd0, 0);
        for (int i = 0; i < c_N; i++) begin p_st[i] = 7'd5; p_en[i] = 7'd6; end
        do_txn(4'b1010, 0, 1, 1'b1, 4'd2, 0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < c_N; i++) begin
                p_st[i] = rnd_node();
                p_en[i] = ($urandom_range(0, 7) == 0) ? p_st[i] : rnd_node();
            end
            do_txn(4'($urandom_range(1, 15)), 0, $urandom_range(0, 30), 1'($urandom),
                   4'($urandom), $urandom_range(0, 5));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
